// File: rtl/mdp3_book_update_sched.sv
`default_nettype none
// ============================================================================
// Module  : mdp3_book_update_sched
// Brief   : Queues parsed MDP3 book messages and applies them to a single-port
//           book RAM as read-modify-write, sharing the RAM with host reads.
// Rev     : 1.0
// ============================================================================
module mdp3_book_update_sched #(
    parameter int QDEPTH       = 4,
    parameter int SEC_BITS     = 4,
    parameter int LVL_BITS     = 3,
    parameter int STARVE_LIMIT = 8,
    parameter int ADDR_W       = SEC_BITS + 1 + LVL_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                msg_valid,
    output logic                msg_ready,
    input  logic [1:0]          msg_action,
    input  logic [1:0]          msg_entry_type,
    input  logic [LVL_BITS-1:0] msg_level,
    input  logic [31:0]         msg_security_id,
    input  logic [63:0]         msg_price,
    input  logic [15:0]         msg_quantity,
    input  logic [7:0]          msg_num_orders,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_rd_en,
    output logic                ram_wr_en,
    output logic [88:0]         ram_wdata,
    input  logic [88:0]         ram_rdata,
    input  logic                host_req,
    input  logic [ADDR_W-1:0]   host_addr,
    output logic                host_ack,
    output logic [88:0]         host_rdata,
    output logic [31:0]         upd_count,
    output logic [15:0]         err_count
);

    localparam int c_PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int c_CNT_W = $clog2(QDEPTH + 1);
    localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_MSG_RD   = 3'd1;
    localparam logic [2:0] c_MSG_MOD  = 3'd2;
    localparam logic [2:0] c_MSG_WR   = 3'd3;
    localparam logic [2:0] c_HOST_RD  = 3'd4;
    localparam logic [2:0] c_HOST_RSP = 3'd5;

    localparam logic [1:0] c_ACT_NEW    = 2'd0;
    localparam logic [1:0] c_ACT_CHANGE = 2'd1;
    localparam logic [1:0] c_ACT_DELETE = 2'd2;
    localparam logic [1:0] c_ACT_BAD    = 2'd3;

    typedef struct packed {
        logic [1:0]          action;
        logic [1:0]          etype;
        logic [LVL_BITS-1:0] level;
        logic [SEC_BITS-1:0] sec;
        logic [63:0]         price;
        logic [15:0]         qty;
        logic [7:0]          orders;
    } msg_t;

    msg_t                r_q_mem [QDEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_q_count;
    logic [c_CNT_W-1:0]  w_q_count_next;
    logic                r_msg_ready;
    logic                w_push;
    logic                w_pop;
    msg_t                w_push_msg;
    msg_t                w_head;
    logic [ADDR_W-1:0]   w_head_addr;
    logic                w_unused_sec;

    logic [2:0]          r_state;
    logic [2:0]          w_state_next;
    logic [c_STV_W-1:0]  r_starve_cnt;
    logic                w_host_grant;
    logic                w_err_inc;
    logic                w_upd_inc;
    logic                w_load_cur;
    logic                w_rd_en_next;
    logic                w_wr_en_next;
    logic [ADDR_W-1:0]   w_addr_next;
    logic [88:0]         w_wdata_next;
    logic                w_ack_next;

    logic                r_ram_rd_en;
    logic                r_ram_wr_en;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [88:0]         r_ram_wdata;
    logic                r_host_ack;
    logic [88:0]         r_host_rdata;
    logic [31:0]         r_upd_count;
    logic [15:0]         r_err_count;

    logic [1:0]          r_cur_action;
    logic [63:0]         r_cur_price;
    logic [15:0]         r_cur_qty;
    logic [7:0]          r_cur_orders;

    assign w_unused_sec = ^msg_security_id[31:SEC_BITS];

    assign w_push     = msg_valid && r_msg_ready;
    assign w_push_msg = '{action: msg_action, etype: msg_entry_type, level: msg_level,
                          sec: msg_security_id[SEC_BITS-1:0], price: msg_price,
                          qty: msg_quantity, orders: msg_num_orders};
    assign w_head      = r_q_mem[r_rd_ptr];
    assign w_head_addr = {w_head.sec, w_head.etype[0], w_head.level};
    assign w_q_count_next = r_q_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_mem[r_wr_ptr] <= w_push_msg;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_host_grant = 1'b0;
        w_err_inc    = 1'b0;
        w_upd_inc    = 1'b0;
        w_load_cur   = 1'b0;
        w_rd_en_next = 1'b0;
        w_wr_en_next = 1'b0;
        w_addr_next  = r_ram_addr;
        w_wdata_next = r_ram_wdata;
        w_ack_next   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if ((r_q_count != '0) &&
                    (!host_req || (r_starve_cnt < c_STV_W'(STARVE_LIMIT)))) begin
                    w_pop = 1'b1;
                    if (w_head.etype[1] || (w_head.action == c_ACT_BAD)) begin
                        w_err_inc = 1'b1;
                    end else if (w_head.action == c_ACT_NEW) begin
                        w_state_next = c_MSG_WR;
                        w_wr_en_next = 1'b1;
                        w_addr_next  = w_head_addr;
                        w_wdata_next = {1'b1, w_head.price, w_head.qty, w_head.orders};
                    end else begin
                        w_state_next = c_MSG_RD;
                        w_rd_en_next = 1'b1;
                        w_addr_next  = w_head_addr;
                        w_load_cur   = 1'b1;
                    end
                // A host_ack cycle still sees the old host_req; skip it to avoid a double grant.
                end else if (host_req && !r_host_ack) begin
                    w_host_grant = 1'b1;
                    w_state_next = c_HOST_RD;
                    w_rd_en_next = 1'b1;
                    w_addr_next  = host_addr;
                end
            end
            c_MSG_RD: begin
                w_state_next = c_MSG_MOD;
            end
            c_MSG_MOD: begin
                if ((r_cur_action == c_ACT_CHANGE) && ram_rdata[88] &&
                    (ram_rdata[87:24] == r_cur_price)) begin
                    w_state_next = c_MSG_WR;
                    w_wr_en_next = 1'b1;
                    w_wdata_next = {1'b1, r_cur_price, r_cur_qty, r_cur_orders};
                end else if ((r_cur_action == c_ACT_DELETE) && ram_rdata[88]) begin
                    w_state_next = c_MSG_WR;
                    w_wr_en_next = 1'b1;
                    w_wdata_next = '0;
                end else begin
                    w_err_inc    = 1'b1;
                    w_state_next = c_IDLE;
                end
            end
            c_MSG_WR: begin
                w_upd_inc    = 1'b1;
                w_state_next = c_IDLE;
            end
            c_HOST_RD: begin
                w_state_next = c_HOST_RSP;
            end
            c_HOST_RSP: begin
                w_ack_next   = 1'b1;
                w_state_next = c_IDLE;
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_q_count    <= '0;
            r_msg_ready  <= 1'b0;
            r_starve_cnt <= '0;
            r_ram_rd_en  <= 1'b0;
            r_ram_wr_en  <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_host_ack   <= 1'b0;
            r_host_rdata <= '0;
            r_upd_count  <= '0;
            r_err_count  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_q_count   <= w_q_count_next;
            r_msg_ready <= (w_q_count_next != c_CNT_W'(QDEPTH));
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_host_grant || !host_req) begin
                r_starve_cnt <= '0;
            end else if (w_pop && (r_starve_cnt != c_STV_W'(STARVE_LIMIT))) begin
                r_starve_cnt <= r_starve_cnt + c_STV_W'(1);
            end
            r_ram_rd_en <= w_rd_en_next;
            r_ram_wr_en <= w_wr_en_next;
            r_ram_addr  <= w_addr_next;
            r_ram_wdata <= w_wdata_next;
            r_host_ack  <= w_ack_next;
            if (r_state == c_HOST_RSP) begin
                r_host_rdata <= ram_rdata;
            end
            if (w_upd_inc && (r_upd_count != '1)) begin
                r_upd_count <= r_upd_count + 32'd1;
            end
            if (w_err_inc && (r_err_count != '1)) begin
                r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_load_cur) begin
            r_cur_action <= w_head.action;
            r_cur_price  <= w_head.price;
            r_cur_qty    <= w_head.qty;
            r_cur_orders <= w_head.orders;
        end
    end

    assign msg_ready  = r_msg_ready;
    assign ram_rd_en  = r_ram_rd_en;
    // A write already scheduled is dropped in the very cycle reset arrives.
    assign ram_wr_en  = r_ram_wr_en && !reset;
    assign ram_addr   = r_ram_addr;
    assign ram_wdata  = r_ram_wdata;
    assign host_ack   = r_host_ack;
    assign host_rdata = r_host_rdata;
    assign upd_count  = r_upd_count;
    assign err_count  = r_err_count;

endmodule
`default_nettype wire

// File: doc/mdp3_book_update_sched.md
Name: mdp3_book_update_sched

Overview:
- Sequences order-book RAM updates from parsed MDP3 messages (parser message_ready / field outputs).
- Buffers messages in a small queue and performs new/change/delete as read-modify-write on a single-port book RAM.
- Arbitrates the same RAM with a host snapshot-read port, with starvation protection.
- Sits between the MDP3 parser and the order-book memory; msg_ready drives the parser's enable_order_book halt.

Parameters:
- QDEPTH, 4: message queue depth (power of 2, >=2).
- SEC_BITS, 4: low SECURITY_ID bits used as security slot.
- LVL_BITS, 3: price-level index width.
- STARVE_LIMIT, 8: consecutive message grants allowed while host_req pending.
- ADDR_W, SEC_BITS+1+LVL_BITS: derived RAM address width.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- msg_valid  in  1  parser message_ready.
- msg_ready  out  1  queue not full; message accepted when msg_valid && msg_ready.
- msg_action  in  2  0=New, 1=Change, 2=Delete, 3=invalid.
- msg_entry_type  in  2  0=Bid, 1=Offer, 2/3=unsupported.
- msg_level  in  LVL_BITS  price level index.
- msg_security_id  in  32  SECURITY_ID.
- msg_price  in  64  PRICE.
- msg_quantity  in  16  QUANTITY.
- msg_num_orders  in  8  NUM_ORDERS.
- ram_addr  out  ADDR_W  {security_id[SEC_BITS-1:0], entry_type[0], level}.
- ram_rd_en  out  1  read strobe; ram_rdata valid next cycle.
- ram_wr_en  out  1  write strobe.
- ram_wdata  out  89  {valid, price[63:0], quantity[15:0], num_orders[7:0]}.
- ram_rdata  in  89  read data, same format.
- host_req  in  1  host read request; held high until host_ack.
- host_addr  in  ADDR_W  host read address.
- host_ack  out  1  one-cycle pulse; host_rdata valid.
- host_rdata  out  89  entry read for host.
- upd_count  out  32  successful RAM writes, saturating.
- err_count  out  16  rejected messages, saturating.

Behaviour:
- Reset: queue flushed; FSM to IDLE; ram_rd_en, ram_wr_en, host_ack, upd_count, err_count, msg_ready all 0. ram_addr, ram_wdata, host_rdata = 0.
- msg_ready is registered: 1 on the first cycle after reset deasserts, then !full.
- Queue push on msg_valid && msg_ready. A simultaneous pop and push when full is not possible because msg_ready=0 when full.
- FSM states: IDLE, MSG_RD, MSG_MOD, MSG_WR, HOST_RD, HOST_RSP.
- IDLE arbitration:
  - Queue non-empty and (!host_req or starve_cnt < STARVE_LIMIT): pop head message.
  - Else if host_req: go to HOST_RD.
  - starve_cnt increments on each message pop while host_req=1. It clears on host grant or when host_req=0.
- Popped message handling:
  - entry_type>=2 or action=3: err_count++, no RAM access, stay IDLE.
  - New: go to MSG_WR and write {1, price, qty, orders}.
  - Change/Delete: go to MSG_RD.
- MSG_RD: ram_rd_en=1 with ram_addr for one cycle.
- MSG_MOD: capture ram_rdata.
  - Change with valid=1 and stored price==msg_price: MSG_WR with {1, price, new qty, new orders}.
  - Delete with valid=1: MSG_WR with all-zero word.
  - Otherwise: err_count++, return to IDLE, no write.
- MSG_WR: ram_wr_en=1 for one cycle; upd_count++; then IDLE.
- HOST_RD: ram_rd_en=1, ram_addr=host_addr.
- HOST_RSP: host_ack=1; host_rdata registered from ram_rdata; then IDLE.
- Latency from pop to write: New = 1 cycle (write in the cycle after the IDLE pop); Change/Delete = 3 cycles.
- Throughput: New = 2 cycles/message; Change/Delete = 4 cycles/message; host read = 3 cycles.
- Hazards: ram_rd_en and ram_wr_en are never both high. Operations are fully serialized, so back-to-back messages to the same address always see the prior write.
- Counters saturate at all-ones.
- Reset mid-operation: any in-flight write is abandoned (ram_wr_en=0 on the reset cycle), queue contents are lost, and a pending host_req is not acked.

Test Plan:
- New, Bid, sec 0x3, lvl 2, price 100, qty 5, orders 1 -> ram_wr_en at addr 0x32 (binary 0011_0_010), wdata valid=1; upd_count=1.
- Change on the same address, price 100, qty 9 -> rd then write qty 9, upd_count=2. Change with price 101 -> no write, err_count=1.
- Delete on the valid entry -> write all-zero. A second Delete -> no write, err_count++.
- Fill queue with 4 messages while FSM busy -> msg_ready=0. The extra msg_valid is not accepted; msg_ready returns 1 after the first pop.
- host_req held with a continuous message stream, STARVE_LIMIT=8 -> host granted after exactly 8 message pops; host_ack one cycle with host_rdata = RAM content.
- Entry_type 2 message -> err_count++, no RAM strobe. Assert reset during MSG_MOD -> next cycle all outputs at reset values, queue empty.
